// File: rtl/fifo_packet_writer_if.sv
// Stream-in / FIFO-write-out bundle for the packet writer.
// The slave side is the writer itself: it consumes the upstream stream
// and drives the async FIFO write port.
interface fifo_packet_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wr_data;

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  fifo_full,
    output s_ready,
    output fifo_wr_en,
    output fifo_wr_data
  );

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output fifo_full,
    input  s_ready,
    input  fifo_wr_en,
    input  fifo_wr_data
  );
endinterface

// File: rtl/fifo_packet_writer.sv
// Packet framer in front of an async FIFO write port.
// Each upstream packet is written as: header {HDR_MARK, seq}, the payload
// bytes (at most MAX_LEN of them), then an XOR checksum trailer. Payload
// beyond MAX_LEN is accepted and discarded, and err_trunc latches.
// Only DATA_WIDTH = 8 and MAX_LEN in 1..255 are meaningful.
module fifo_packet_writer #(
  parameter int         DATA_WIDTH = 8,
  parameter logic [3:0] HDR_MARK   = 4'hA,
  parameter int         MAX_LEN    = 16
) (
  input  logic                 wr_clk,
  input  logic                 rst,
  fifo_packet_writer_if.slave  bus,
  output logic                 busy,
  output logic [15:0]          pkt_count,
  output logic                 err_trunc
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PAY  = 3'd2,
    TRL  = 3'd3,
    DROP = 3'd4
  } state_t;

  // Beat index of the last payload byte a packet may carry.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_LEN - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_seq;
  logic [DATA_WIDTH-1:0] r_csum;
  logic [7:0]            r_beats;
  logic                  r_trunc;
  logic [15:0]           r_pkt_count;
  logic                  r_err_trunc;

  logic                  w_s_ready;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic                  w_hdr_wr;
  logic                  w_beat_acc;
  logic                  w_beat_cut;
  logic                  w_trl_wr;
  logic                  w_drop_end;

  // State register; an asserted rst abandons any packet in flight at once.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, handshake and FIFO word; nothing moves while the FIFO is full.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = '0;
    w_hdr_wr    = 1'b0;
    w_beat_acc  = 1'b0;
    w_beat_cut  = 1'b0;
    w_trl_wr    = 1'b0;
    w_drop_end  = 1'b0;
    case (r_state)
      IDLE: begin
        // s_valid only wakes us up; the beat itself is taken in PAY.
        if (bus.s_valid) w_state_nxt = HDR;
      end
      HDR: begin
        w_wr_data = {HDR_MARK, r_seq};
        w_wr_en   = !bus.fifo_full;
        if (!bus.fifo_full) begin
          w_hdr_wr    = 1'b1;
          w_state_nxt = PAY;
        end
      end
      PAY: begin
        w_s_ready = !bus.fifo_full;
        w_wr_en   = bus.s_valid && !bus.fifo_full;
        w_wr_data = bus.s_data;
        if (bus.s_valid && !bus.fifo_full) begin
          w_beat_acc = 1'b1;
          w_beat_cut = !bus.s_last && (r_beats == LAST_BEAT);
          if (bus.s_last || (r_beats == LAST_BEAT)) w_state_nxt = TRL;
        end
      end
      TRL: begin
        w_wr_data = r_csum;
        w_wr_en   = !bus.fifo_full;
        if (!bus.fifo_full) begin
          w_trl_wr    = 1'b1;
          w_state_nxt = r_trunc ? DROP : IDLE;
        end
      end
      DROP: begin
        // Swallow the oversize tail of a truncated packet, full or not.
        w_s_ready = 1'b1;
        if (bus.s_valid && bus.s_last) begin
          w_drop_end  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Per-packet checksum and beat count, restarted by every header write.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_csum  <= '0;
      r_beats <= '0;
    end else if (w_hdr_wr) begin
      r_csum  <= '0;
      r_beats <= '0;
    end else if (w_beat_acc) begin
      r_csum  <= r_csum ^ bus.s_data;
      r_beats <= r_beats + 8'd1;
    end
  end

  // Sequence number and completed-packet count advance on the trailer write.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_seq       <= '0;
      r_pkt_count <= '0;
    end else if (w_trl_wr) begin
      r_seq       <= r_seq + 4'd1;
      r_pkt_count <= r_pkt_count + 16'd1;
    end
  end

  // Truncation tracking: pending until the dropped tail ends, sticky error.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      r_trunc     <= 1'b0;
      r_err_trunc <= 1'b0;
    end else begin
      if (w_beat_cut) begin
        r_trunc     <= 1'b1;
        r_err_trunc <= 1'b1;
      end else if (w_drop_end) begin
        r_trunc     <= 1'b0;
      end
    end
  end

  assign bus.s_ready      = w_s_ready;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_wr_data = w_wr_data;
  assign busy             = (r_state != IDLE);
  assign pkt_count        = r_pkt_count;
  assign err_trunc        = r_err_trunc;

endmodule

// File: tb/tb_fifo_packet_writer.sv
// Directed and randomized checks of fifo_packet_writer (MAX_LEN = 4)
// against a packet-level reference model of the FIFO word stream.
module tb_fifo_packet_writer;

  localparam int MAX_LEN = 4;

  logic        wr_clk = 1'b0;
  logic        rst    = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;
  logic        err_trunc;

  fifo_packet_writer_if #(.DATA_WIDTH(8)) bus ();

  fifo_packet_writer #(
    .DATA_WIDTH (8),
    .HDR_MARK   (4'hA),
    .MAX_LEN    (MAX_LEN)
  ) dut (
    .wr_clk    (wr_clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .pkt_count (pkt_count),
    .err_trunc (err_trunc)
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] got_q[$];
  int         stamp_q[$];
  logic [7:0] exp_q[$];

  // reference model state
  logic [3:0]  m_seq = 4'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        m_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  always @(posedge wr_clk) cyc++;

  // Monitor: capture FIFO writes and police the write strobe.
  always @(negedge wr_clk) begin
    if (rst) begin
      chk("wr_en_in_reset", bus.fifo_wr_en, 1'b0);
    end else begin
      if (bus.fifo_full) chk("wr_en_while_full", bus.fifo_wr_en, 1'b0);
      if (bus.fifo_wr_en) begin
        got_q.push_back(bus.fifo_wr_data);
        stamp_q.push_back(cyc);
      end
    end
  end

  // Expected FIFO words for one packet as seen on the upstream bus.
  task automatic model_pkt(input logic [7:0] d[$]);
    int         n;
    logic [7:0] x;
    n = (d.size() > MAX_LEN) ? MAX_LEN : d.size();
    x = 8'h00;
    exp_q.push_back({4'hA, m_seq});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      x = x ^ d[i];
    end
    exp_q.push_back(x);
    m_seq = m_seq + 4'd1;
    m_cnt = m_cnt + 16'd1;
    if (d.size() > MAX_LEN) m_err = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},    busy, 1'b0);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_wr_en"},   bus.fifo_wr_en, 1'b0);
    chk({tag, "_wr_data"}, bus.fifo_wr_data, 8'h00);
    chk({tag, "_pkt_cnt"}, pkt_count, 16'h0);
    chk({tag, "_err"},     err_trunc, 1'b0);
  endtask

  task automatic clear_all();
    got_q.delete();
    stamp_q.delete();
    exp_q.delete();
    m_seq = 4'd0;
    m_cnt = 16'd0;
    m_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0; bus.fifo_full = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    clear_all();
    @(posedge wr_clk); #1;
  endtask

  // Offer one packet; fifo_full is random (pct) or forced in [win_lo, win_hi).
  task automatic drive_pkt(input logic [7:0] d[$], input int pct, input int win_lo, input int win_hi);
    int   i = 0;
    int   c = 0;
    logic acc;
    model_pkt(d);
    while (i < d.size()) begin
      bus.s_valid = 1'b1;
      bus.s_data  = d[i];
      bus.s_last  = (i == d.size() - 1);
      if (c >= win_lo && c < win_hi) bus.fifo_full = 1'b1;
      else bus.fifo_full = ($urandom_range(99) < pct);
      @(negedge wr_clk);
      if (c >= win_lo && c < win_hi) begin
        chk($sformatf("bp_s_ready_c%0d", c), bus.s_ready, 1'b0);
        chk($sformatf("bp_wr_en_c%0d", c), bus.fifo_wr_en, 1'b0);
      end
      acc = bus.s_valid && bus.s_ready;
      @(posedge wr_clk); #1;
      if (acc) i++;
      c++;
      if (c > 600) begin
        chk("drive_timeout", 1, 0);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.fifo_full = 1'b0;
    while (busy && k < 50) begin
      @(posedge wr_clk); #1;
      k++;
    end
    chk("drain_idle", busy, 1'b0);
    repeat (2) @(posedge wr_clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    chk({tag, "_pkt_count"}, pkt_count, m_cnt);
    chk({tag, "_err_trunc"}, err_trunc, m_err);
  endtask

  initial begin
    logic [7:0] p[$];
    int         len;

    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0; bus.fifo_full = 1'b0;

    // Basic packet, consecutive writes
    do_reset();
    p = '{8'h01, 8'h02, 8'h04};
    drive_pkt(p, 0, -1, -1);
    drain();
    cmp_stream("basic");
    if (got_q.size() == 5) begin
      chk("basic_hdr", got_q[0], 8'hA0);
      chk("basic_trl", got_q[4], 8'h07);
      for (int i = 1; i < 5; i++)
        chk($sformatf("basic_consec%0d", i), stamp_q[i] - stamp_q[0], i);
    end else begin
      chk("basic_count", got_q.size(), 5);
    end

    // Backpressure: full for 3 cycles while in PAY
    do_reset();
    p = '{8'h21, 8'h22, 8'h23, 8'h24};
    drive_pkt(p, 0, 3, 6);
    drain();
    cmp_stream("bp");

    // Truncation at MAX_LEN = 4, then next header carries seq 1
    do_reset();
    p = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    drive_pkt(p, 0, -1, -1);
    drain();
    chk("trunc_err", err_trunc, 1'b1);
    p = '{8'h99};
    drive_pkt(p, 0, -1, -1);
    drain();
    cmp_stream("trunc");
    if (got_q.size() >= 7) begin
      chk("trunc_csum", got_q[5], 8'h00);
      chk("trunc_next_hdr", got_q[6], 8'hA1);
    end

    // Sequence wrap: 17 one-byte packets
    do_reset();
    for (int k = 0; k < 17; k++) begin
      p = '{8'($urandom_range(255))};
      drive_pkt(p, 0, -1, -1);
    end
    drain();
    cmp_stream("wrap");
    if (got_q.size() == 51) begin
      for (int k = 0; k < 17; k++)
        chk($sformatf("wrap_hdr%0d", k), got_q[3*k], 8'hA0 | 8'(k % 16));
    end
    chk("wrap_pkt_count", pkt_count, 16'd17);

    // Reset mid-PAY after two beats: no trailer, clean restart
    do_reset();
    bus.s_valid = 1'b1; bus.s_data = 8'h31; bus.s_last = 1'b0;
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    @(posedge wr_clk); #1;
    bus.s_data = 8'h32;
    @(posedge wr_clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    bus.s_valid = 1'b0;
    repeat (2) @(posedge wr_clk);
    #1;
    exp_q = '{8'hA0, 8'h31, 8'h32};
    cmp_stream("midrst_pre");
    rst = 1'b0;
    clear_all();
    @(posedge wr_clk); #1;
    p = '{8'h77};
    drive_pkt(p, 0, -1, -1);
    drain();
    cmp_stream("midrst_post");
    if (got_q.size() > 0) chk("midrst_hdr", got_q[0], 8'hA0);

    // Full on entry to HDR and to TRL
    do_reset();
    bus.fifo_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h5A; bus.s_last = 1'b1;
    @(posedge wr_clk); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wr_clk);
      chk($sformatf("hdrfull_wr_en%0d", k), bus.fifo_wr_en, 1'b0);
      chk($sformatf("hdrfull_busy%0d", k), busy, 1'b1);
      @(posedge wr_clk); #1;
    end
    bus.fifo_full = 1'b0;
    @(negedge wr_clk);
    chk("hdr_write", bus.fifo_wr_en, 1'b1);
    @(posedge wr_clk); #1;
    @(negedge wr_clk);
    chk("pay_ready", bus.s_ready, 1'b1);
    @(posedge wr_clk); #1;
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge wr_clk);
      chk($sformatf("trlfull_wr_en%0d", k), bus.fifo_wr_en, 1'b0);
      chk($sformatf("trlfull_cnt%0d", k), pkt_count, 16'd0);
      @(posedge wr_clk); #1;
    end
    bus.fifo_full = 1'b0;
    drain();
    exp_q = '{8'hA0, 8'h5A, 8'h5A};
    m_cnt = 16'd1;
    cmp_stream("hdrtrl_full");

    // Randomized packets with random backpressure
    do_reset();
    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(1, MAX_LEN + 2);
      p.delete();
      for (int j = 0; j < len; j++) p.push_back(8'($urandom_range(255)));
      drive_pkt(p, 30, -1, -1);
    end
    drain();
    cmp_stream("random");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
